// File: rtl/id_issue_sequencer.sv
// ID-stage issue controller: issues decoded instructions to EXE, inserts bubbles on
// RAW/load-use hazards and serialises syscall-class instructions through a drain sequence.
module id_issue_sequencer #(
    parameter int BUBBLE_DEPTH   = 4,
    parameter int REG_W          = 5,
    parameter bit HAS_FORWARDING = 1'b1,
    parameter int STALL_CNT_W    = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FLUSH,
    input  logic                   Instr_valid_IN,
    input  logic                   Syscall_IN,
    input  logic                   LLSC_IN,
    input  logic [REG_W-1:0]       RegA_IN,
    input  logic [REG_W-1:0]       RegB_IN,
    input  logic                   UseA_IN,
    input  logic                   UseB_IN,
    input  logic [REG_W-1:0]       EXE_WriteReg_IN,
    input  logic                   EXE_RegWrite_IN,
    input  logic                   EXE_MemRead_IN,
    input  logic [REG_W-1:0]       MEM_WriteReg_IN,
    input  logic                   MEM_RegWrite_IN,
    output logic                   Issue_OUT,
    output logic                   Bubble_OUT,
    output logic                   Sys_Issue_OUT,
    output logic                   SYS,
    output logic                   WANT_FREEZE,
    output logic [1:0]             State_OUT,
    output logic [STALL_CNT_W-1:0] Stall_count_OUT
);

    localparam int               CNT_W      = $clog2(BUBBLE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(BUBBLE_DEPTH - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_SIGNAL  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;

    logic src_a;
    logic src_b;
    logic exe_hit;
    logic mem_hit;
    logic hz;
    logic sys_req;

    // Register 0 is hardwired to zero, so reading it can never create a dependency.
    assign src_a   = Instr_valid_IN && UseA_IN && (RegA_IN != '0);
    assign src_b   = Instr_valid_IN && UseB_IN && (RegB_IN != '0);
    assign sys_req = Instr_valid_IN && Syscall_IN;

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        exe_hit = (src_a && (RegA_IN == EXE_WriteReg_IN)) ||
                  (src_b && (RegB_IN == EXE_WriteReg_IN));
        mem_hit = (src_a && (RegA_IN == MEM_WriteReg_IN)) ||
                  (src_b && (RegB_IN == MEM_WriteReg_IN));
        hz      = 1'b0;
        if (HAS_FORWARDING) begin
            hz = exe_hit && EXE_RegWrite_IN && EXE_MemRead_IN;
        end else begin
            hz = (exe_hit && EXE_RegWrite_IN) || (mem_hit && MEM_RegWrite_IN);
        end
    end

    // SIGNAL and RELEASE fall outside both terms, which releases fetch for the hand-off.
    assign WANT_FREEZE = (state == ST_DRAIN) ||
                         ((state == ST_IDLE) && (sys_req || hz));
    assign State_OUT   = state;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= ST_IDLE;
            drain_cnt       <= '0;
            Issue_OUT       <= 1'b0;
            Bubble_OUT      <= 1'b0;
            Sys_Issue_OUT   <= 1'b0;
            SYS             <= 1'b0;
            Stall_count_OUT <= '0;
        end else if (FLUSH) begin
            // NOTE: a flush discards the in-flight sequence but keeps the performance count.
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            Issue_OUT     <= 1'b0;
            Bubble_OUT    <= 1'b0;
            Sys_Issue_OUT <= 1'b0;
            SYS           <= 1'b0;
        end else begin
            Issue_OUT     <= 1'b0;
            Bubble_OUT    <= 1'b0;
            Sys_Issue_OUT <= 1'b0;
            SYS           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sys_req) begin
                        state      <= ST_DRAIN;
                        drain_cnt  <= DRAIN_INIT;
                        Bubble_OUT <= 1'b1;
                    end else if (hz) begin
                        Bubble_OUT <= 1'b1;
                        if (Stall_count_OUT != '1) begin
                            Stall_count_OUT <= Stall_count_OUT + STALL_CNT_W'(1);
                        end
                    end else begin
                        Issue_OUT <= Instr_valid_IN;
                    end
                end
                ST_DRAIN: begin
                    Bubble_OUT <= 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_SIGNAL;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                ST_SIGNAL: begin
                    SYS        <= !LLSC_IN;
                    Bubble_OUT <= 1'b1;
                    state      <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    Issue_OUT     <= 1'b1;
                    Sys_Issue_OUT <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_issue_sequencer.sv
// Scoreboard bench for id_issue_sequencer: directed stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares them against the selected instance.
module tb_id_issue_sequencer;

    localparam int         REG_W = 5;
    localparam int         BD    = 4;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_SIGNAL  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;
    localparam logic [6:0] ZEROS     = 7'd0;

    logic             CLK = 1'b0;
    logic             RESET, FLUSH, Instr_valid_IN, Syscall_IN, LLSC_IN;
    logic [REG_W-1:0] RegA_IN, RegB_IN, EXE_WriteReg_IN, MEM_WriteReg_IN;
    logic             UseA_IN, UseB_IN, EXE_RegWrite_IN, EXE_MemRead_IN, MEM_RegWrite_IN;

    // Instance with forwarding and a 32-bit counter.
    logic        f_issue, f_bubble, f_sys_issue, f_sys, f_freeze;
    logic [1:0]  f_state;
    logic [31:0] f_cnt;
    // Instance without forwarding and a 4-bit counter.
    logic        n_issue, n_bubble, n_sys_issue, n_sys, n_freeze;
    logic [1:0]  n_state;
    logic [3:0]  n_cnt;

    id_issue_sequencer #(.BUBBLE_DEPTH(BD), .REG_W(REG_W), .HAS_FORWARDING(1'b1), .STALL_CNT_W(32)) u_fwd (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .Instr_valid_IN(Instr_valid_IN),
        .Syscall_IN(Syscall_IN), .LLSC_IN(LLSC_IN), .RegA_IN(RegA_IN), .RegB_IN(RegB_IN),
        .UseA_IN(UseA_IN), .UseB_IN(UseB_IN), .EXE_WriteReg_IN(EXE_WriteReg_IN),
        .EXE_RegWrite_IN(EXE_RegWrite_IN), .EXE_MemRead_IN(EXE_MemRead_IN),
        .MEM_WriteReg_IN(MEM_WriteReg_IN), .MEM_RegWrite_IN(MEM_RegWrite_IN),
        .Issue_OUT(f_issue), .Bubble_OUT(f_bubble), .Sys_Issue_OUT(f_sys_issue), .SYS(f_sys),
        .WANT_FREEZE(f_freeze), .State_OUT(f_state), .Stall_count_OUT(f_cnt)
    );

    id_issue_sequencer #(.BUBBLE_DEPTH(BD), .REG_W(REG_W), .HAS_FORWARDING(1'b0), .STALL_CNT_W(4)) u_nf (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .Instr_valid_IN(Instr_valid_IN),
        .Syscall_IN(Syscall_IN), .LLSC_IN(LLSC_IN), .RegA_IN(RegA_IN), .RegB_IN(RegB_IN),
        .UseA_IN(UseA_IN), .UseB_IN(UseB_IN), .EXE_WriteReg_IN(EXE_WriteReg_IN),
        .EXE_RegWrite_IN(EXE_RegWrite_IN), .EXE_MemRead_IN(EXE_MemRead_IN),
        .MEM_WriteReg_IN(MEM_WriteReg_IN), .MEM_RegWrite_IN(MEM_RegWrite_IN),
        .Issue_OUT(n_issue), .Bubble_OUT(n_bubble), .Sys_Issue_OUT(n_sys_issue), .SYS(n_sys),
        .WANT_FREEZE(n_freeze), .State_OUT(n_state), .Stall_count_OUT(n_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        bit          sel;
        logic [6:0]  flags;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Flags order: issue, bubble, sys_issue, sys, want_freeze, state[1:0].
    function automatic logic [6:0] outs(input logic iss, input logic bub, input logic si,
                                        input logic sys, input logic wf, input logic [1:0] st);
        return {iss, bub, si, sys, wf, st};
    endfunction

    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [6:0]  got_f;
            logic [31:0] got_c;
            e     = sb.pop_front();
            got_f = e.sel ? {n_issue, n_bubble, n_sys_issue, n_sys, n_freeze, n_state}
                          : {f_issue, f_bubble, f_sys_issue, f_sys, f_freeze, f_state};
            got_c = e.sel ? 32'(n_cnt) : f_cnt;
            n_checks++;
            if (got_f === e.flags && got_c === e.cnt) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got iss/bub/si/sys/wf/st=%b cnt=%0d, expected %b cnt=%0d",
                         e.name, got_f, got_c, e.flags, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ex(input string name, input bit sel, input logic [6:0] flags, input logic [31:0] cnt);
        exp_t e;
        e.name  = name;
        e.sel   = sel;
        e.flags = flags;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    task automatic cyc(input string name, input bit sel, input logic [6:0] flags, input logic [31:0] cnt);
        ex(name, sel, flags, cnt);
        tick();
    endtask

    task automatic clear_in();
        Instr_valid_IN  = 1'b0; Syscall_IN = 1'b0; LLSC_IN = 1'b0;
        RegA_IN = '0; RegB_IN = '0; UseA_IN = 1'b0; UseB_IN = 1'b0;
        EXE_WriteReg_IN = '0; EXE_RegWrite_IN = 1'b0; EXE_MemRead_IN = 1'b0;
        MEM_WriteReg_IN = '0; MEM_RegWrite_IN = 1'b0;
    endtask

    task automatic set_load(input logic [REG_W-1:0] r);
        Instr_valid_IN  = 1'b1;
        RegA_IN         = r;
        UseA_IN         = 1'b1;
        EXE_WriteReg_IN = r;
        EXE_RegWrite_IN = 1'b1;
        EXE_MemRead_IN  = 1'b1;
    endtask

    // Full serialising sequence, accepted on the edge after the first row.
    task automatic syscall_seq(input string tag, input logic llsc, input logic [31:0] cnt);
        Instr_valid_IN = 1'b1;
        Syscall_IN     = 1'b1;
        LLSC_IN        = llsc;
        cyc({tag, "_accept"}, 0, outs(0, 0, 0, 0, 1, S_IDLE), cnt);
        for (int i = 0; i < BD - 1; i++) cyc({tag, "_drain"}, 0, outs(0, 1, 0, 0, 1, S_DRAIN), cnt);
        cyc({tag, "_signal"}, 0, outs(0, 1, 0, 0, 0, S_SIGNAL), cnt);
        cyc({tag, "_release"}, 0, outs(0, 1, 0, !llsc, 0, S_RELEASE), cnt);
        clear_in();
        cyc({tag, "_issue"}, 0, outs(1, 0, 1, 0, 0, S_IDLE), cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        RESET = 1'b1;
        FLUSH = 1'b0;
        tick();
        tick();
        RESET = 1'b0;

        // Reset values and a plain five-instruction stream.
        ex("reset_nf", 1, ZEROS, 0);
        cyc("reset_fwd", 0, ZEROS, 0);
        for (int k = 0; k < 5; k++) begin
            Instr_valid_IN = 1'b1;
            cyc("plain", 0, outs(k > 0, 0, 0, 0, 0, S_IDLE), 0);
        end
        Instr_valid_IN = 1'b0;
        cyc("plain_last", 0, outs(1, 0, 0, 0, 0, S_IDLE), 0);

        // Syscall sequence, then the LL/SC flavour with SYS suppressed.
        syscall_seq("sys", 1'b0, 0);
        syscall_seq("llsc", 1'b1, 0);

        // Load-use with forwarding, plus the register-0 and non-load escapes.
        set_load(5'd8);
        cyc("lu_detect", 0, outs(0, 0, 0, 0, 1, S_IDLE), 0);
        EXE_RegWrite_IN = 1'b0;
        EXE_MemRead_IN  = 1'b0;
        cyc("lu_bubble", 0, outs(0, 1, 0, 0, 0, S_IDLE), 1);
        set_load(5'd0);
        cyc("lu_issue_r0_clear", 0, outs(1, 0, 0, 0, 0, S_IDLE), 1);
        set_load(5'd8);
        EXE_MemRead_IN = 1'b0;
        cyc("r0_issue_nonload_clear", 0, outs(1, 0, 0, 0, 0, S_IDLE), 1);
        UseA_IN        = 1'b0;
        RegB_IN        = 5'd8;
        UseB_IN        = 1'b1;
        EXE_MemRead_IN = 1'b1;
        cyc("lu_b_detect", 0, outs(1, 0, 0, 0, 1, S_IDLE), 1);
        clear_in();
        cyc("lu_b_bubble", 0, outs(0, 1, 0, 0, 0, S_IDLE), 2);

        // No forwarding: MEM-stage RAW stall and 4-bit counter saturation.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        Instr_valid_IN  = 1'b1;
        RegB_IN         = 5'd5;
        UseB_IN         = 1'b1;
        MEM_WriteReg_IN = 5'd5;
        MEM_RegWrite_IN = 1'b1;
        ex("mem_fwd_clear", 0, outs(0, 0, 0, 0, 0, S_IDLE), 0);
        cyc("mem_detect", 1, outs(0, 0, 0, 0, 1, S_IDLE), 0);
        for (int i = 1; i <= 16; i++) begin
            ex("mem_fwd_issue", 0, outs(1, 0, 0, 0, 0, S_IDLE), 0);
            cyc("sat", 1, outs(0, 1, 0, 0, 1, S_IDLE), (i > 15) ? 15 : i);
        end
        clear_in();
        cyc("sat_hold", 1, outs(0, 1, 0, 0, 0, S_IDLE), 15);
        Instr_valid_IN  = 1'b1;
        RegA_IN         = 5'd9;
        UseA_IN         = 1'b1;
        EXE_WriteReg_IN = 5'd9;
        EXE_RegWrite_IN = 1'b1;
        ex("exe_fwd_clear", 0, outs(0, 0, 0, 0, 0, S_IDLE), 0);
        cyc("exe_detect_nf", 1, outs(0, 0, 0, 0, 1, S_IDLE), 15);
        clear_in();
        cyc("exe_bubble_nf", 1, outs(0, 1, 0, 0, 0, S_IDLE), 15);

        // Three load-use stalls bring the forwarding counter to 3.
        set_load(5'd8);
        for (int i = 0; i < 3; i++) cyc("lu_hold", 0, outs(0, i > 0, 0, 0, 1, S_IDLE), i);
        clear_in();
        cyc("lu_hold_end", 0, outs(0, 1, 0, 0, 0, S_IDLE), 3);

        // Flush in DRAIN.
        Instr_valid_IN = 1'b1;
        Syscall_IN     = 1'b1;
        cyc("fl_drain_accept", 0, outs(0, 0, 0, 0, 1, S_IDLE), 3);
        FLUSH = 1'b1;
        cyc("fl_drain_cycle", 0, outs(0, 1, 0, 0, 1, S_DRAIN), 3);
        FLUSH = 1'b0;
        clear_in();
        cyc("fl_drain_after", 0, ZEROS, 3);

        // Flush in SIGNAL: SYS must never rise.
        Instr_valid_IN = 1'b1;
        Syscall_IN     = 1'b1;
        cyc("fl_sig_accept", 0, outs(0, 0, 0, 0, 1, S_IDLE), 3);
        for (int i = 0; i < BD - 1; i++) cyc("fl_sig_drain", 0, outs(0, 1, 0, 0, 1, S_DRAIN), 3);
        FLUSH = 1'b1;
        cyc("fl_sig_cycle", 0, outs(0, 1, 0, 0, 0, S_SIGNAL), 3);
        FLUSH = 1'b0;
        clear_in();
        cyc("fl_sig_after", 0, ZEROS, 3);
        cyc("fl_sig_quiet", 0, ZEROS, 3);

        // Flush beats a syscall and a hazard presented in IDLE.
        FLUSH          = 1'b1;
        Instr_valid_IN = 1'b1;
        Syscall_IN     = 1'b1;
        cyc("fl_idle_sys", 0, outs(0, 0, 0, 0, 1, S_IDLE), 3);
        clear_in();
        set_load(5'd8);
        cyc("fl_idle_sys_after", 0, outs(0, 0, 0, 0, 1, S_IDLE), 3);
        FLUSH = 1'b0;
        clear_in();
        cyc("fl_hz_after", 0, ZEROS, 3);

        // Reset mid-DRAIN clears the counter too.
        Instr_valid_IN = 1'b1;
        Syscall_IN     = 1'b1;
        cyc("rst_accept", 0, outs(0, 0, 0, 0, 1, S_IDLE), 3);
        RESET = 1'b1;
        cyc("rst_drain", 0, outs(0, 1, 0, 0, 1, S_DRAIN), 3);
        RESET = 1'b0;
        clear_in();
        ex("rst_after_nf", 1, ZEROS, 0);
        cyc("rst_after", 0, ZEROS, 0);

        // Back-to-back syscalls: the second reaches decode one cycle after the first issues,
        // so the SYS pulses land 7 edges apart and neither is lost or merged.
        syscall_seq("b2b_first", 1'b0, 0);
        syscall_seq("b2b_second", 1'b0, 0);
        cyc("b2b_end", 0, ZEROS, 0);

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
